// File: rtl/code_seq_checker_if.sv
// code_seq_checker_if: strobe/code inputs and status outputs of code_seq_checker; seg exists only with CODE_SEQ_CHK_SEG_EN
interface code_seq_checker_if;
  logic       en;
  logic [3:0] code;
  logic [3:0] value;
  logic       legal;
  logic       step_ok;
  logic       err;
  logic [7:0] err_cnt;
  logic       done;
  logic [1:0] state;
`ifdef CODE_SEQ_CHK_SEG_EN
  logic [6:0] seg;
  modport master(output en, code, input value, legal, step_ok, err, err_cnt, done, state, seg);
  modport slave(input en, code, output value, legal, step_ok, err, err_cnt, done, state, seg);
`else
  modport master(output en, code, input value, legal, step_ok, err, err_cnt, done, state);
  modport slave(input en, code, output value, legal, step_ok, err, err_cnt, done, state);
`endif
endinterface

// File: rtl/code_seq_checker.sv
// code_seq_checker: decodes a strobed 4-bit code stream and checks it counts like its generator; CODE_SEQ_CHK_SEG_EN adds a 7-segment output
module code_seq_checker #(
  parameter int CODE     = 0,
  parameter int HOLD_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  code_seq_checker_if.slave bus
);
  localparam int         CT     = (CODE >= 0 && CODE <= 4) ? CODE : 0;
  localparam logic [3:0] TERM   = (CT == 0 || CT == 2) ? 4'd15 : 4'd9;
  localparam logic [3:0] HMAX   = 4'(HOLD_MAX);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [1:0] state, nstate;
  logic [3:0] prev, nprev, hold_cnt, nhold, dval;
  logic       dlegal, nstep, nerr, is_next;
  // Decode the sampled word into a digit value and a legality flag for the selected code
  always_comb begin
    dlegal = 1'b1;
    dval   = bus.code;
    if (CT == 1) dlegal = bus.code <= 4'd9;
    else if (CT == 2) dval = {bus.code[3], ^bus.code[3:2], ^bus.code[3:1], ^bus.code};
    else if (CT == 3) begin
      dlegal = bus.code <= 4'd4 || bus.code >= 4'd11;
      dval   = bus.code >= 4'd11 ? bus.code - 4'd6 : bus.code;
    end else if (CT == 4) begin
      dlegal = bus.code >= 4'd3 && bus.code <= 4'd12;
      dval   = bus.code - 4'd3;
    end
  end
  // +1 is compared without wrap so 0 after 15 is a skip, not a step
  assign is_next = {1'b0, dval} == {1'b0, prev} + 5'd1;
  // Sequence tracking: next state, prev/hold bookkeeping and event pulses
  always_comb begin
    nstate = state;
    nprev  = prev;
    nhold  = hold_cnt;
    nstep  = 1'b0;
    nerr   = 1'b0;
    if (bus.en) begin
      case (state)
        S_IDLE: if (dlegal && dval == 4'd0) begin
          nstate = S_TRACK;
          nprev  = 4'd0;
          nhold  = 4'd0;
        end
        S_TRACK: if (!dlegal) nerr = 1'b1;
        else if (is_next) begin
          nstep  = 1'b1;
          nprev  = dval;
          nhold  = 4'd0;
          nstate = dval == TERM ? S_DONE : S_TRACK;
        end else if (dval == prev) begin
          nerr  = hold_cnt + 4'd1 == HMAX;
          nhold = nerr ? 4'd0 : hold_cnt + 4'd1;
        end else begin
          nerr   = 1'b1;
          nprev  = dval;
          nhold  = 4'd0;
          nstate = dval == TERM ? S_DONE : S_TRACK;
        end
        default: if (!(dlegal && dval == TERM)) begin
          nstate = S_TRACK;
          nerr   = !(dlegal && dval == 4'd0);
          nprev  = dlegal ? dval : prev;
          nhold  = 4'd0;
        end
      endcase
    end
  end
  // Register state and all outputs; err_cnt saturates at 255
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      prev        <= 4'd0;
      hold_cnt    <= 4'd0;
      bus.value   <= 4'd0;
      bus.legal   <= 1'b0;
      bus.step_ok <= 1'b0;
      bus.err     <= 1'b0;
      bus.err_cnt <= 8'd0;
      bus.done    <= 1'b0;
    end else begin
      state       <= nstate;
      prev        <= nprev;
      hold_cnt    <= nhold;
      bus.step_ok <= nstep;
      bus.err     <= nerr;
      bus.done    <= nstate == S_DONE;
      if (nerr && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
      if (bus.en) bus.legal <= dlegal;
      if (bus.en && dlegal) bus.value <= dval;
    end
  end
  assign bus.state = state;
`ifdef CODE_SEQ_CHK_SEG_EN
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // Segment pattern follows value; an illegal sample shows a dash
  always_ff @(posedge clk) begin
    if (rst) bus.seg <= 7'b0000000;
    else if (bus.en) bus.seg <= dlegal ? GLYPH[dval] : 7'b1000000;
  end
`endif
endmodule

// File: tb/tb_code_seq_checker.sv
// tb_code_seq_checker: one checker per code type driven by directed and random streams against a spec-level model
module tb_code_seq_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0]      en_d = '0;
  logic [4:0][3:0] code_d = '0;
  logic [4:0][3:0] o_val, o_prev, o_hold;
  logic [4:0][7:0] o_cnt;
  logic [4:0][1:0] o_st;
  logic [4:0]      o_leg, o_stp, o_err, o_done;
`ifdef CODE_SEQ_CHK_SEG_EN
  logic [4:0][6:0] o_seg;
`endif
  int tests = 0, fails = 0;
  int m_st[5], m_prev[5], m_hold[5], m_val[5], m_leg[5], m_cnt[5], m_stp[5], m_err[5];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g
    code_seq_checker_if ifc();
    code_seq_checker #(.CODE(k), .HOLD_MAX(4)) dut (.clk(clk), .rst(rst), .bus(ifc));
    assign ifc.en    = en_d[k];
    assign ifc.code  = code_d[k];
    assign o_val[k]  = ifc.value;
    assign o_leg[k]  = ifc.legal;
    assign o_stp[k]  = ifc.step_ok;
    assign o_err[k]  = ifc.err;
    assign o_cnt[k]  = ifc.err_cnt;
    assign o_done[k] = ifc.done;
    assign o_st[k]   = ifc.state;
    assign o_prev[k] = dut.prev;
    assign o_hold[k] = dut.hold_cnt;
`ifdef CODE_SEQ_CHK_SEG_EN
    assign o_seg[k]  = ifc.seg;
`endif
  end

  function automatic int term(int ct);
    return (ct == 0 || ct == 2) ? 15 : 9;
  endfunction

  // Returns the digit for word w in code ct, or -1 when w is not a code word
  function automatic int dec(int ct, int w);
    int v, b;
    v = 0;
    b = 0;
    case (ct)
      1: return w <= 9 ? w : -1;
      2: begin
        for (int i = 3; i >= 0; i--) begin
          b = b ^ ((w >> i) & 1);
          v = v * 2 + b;
        end
        return v;
      end
      3: return w <= 4 ? w : (w >= 11 ? w - 6 : -1);
      4: return (w >= 3 && w <= 12) ? w - 3 : -1;
      default: return w;
    endcase
  endfunction

  function automatic int enc(int ct, int v);
    case (ct)
      2: return v ^ (v >> 1);
      3: return v <= 4 ? v : v + 6;
      4: return v + 3;
      default: return v;
    endcase
  endfunction

  task automatic upd(int k);
    int d, t;
    t = term(k);
    m_stp[k] = 0;
    m_err[k] = 0;
    if (rst) begin
      m_st[k] = 0; m_prev[k] = 0; m_hold[k] = 0; m_val[k] = 0; m_leg[k] = 0; m_cnt[k] = 0;
    end else if (en_d[k]) begin
      d = dec(k, int'(code_d[k]));
      m_leg[k] = d >= 0 ? 1 : 0;
      if (d >= 0) m_val[k] = d;
      if (m_st[k] == 0) begin
        if (d == 0) begin m_st[k] = 1; m_prev[k] = 0; m_hold[k] = 0; end
      end else if (m_st[k] == 1) begin
        if (d < 0) m_err[k] = 1;
        else if (d == m_prev[k] + 1) begin
          m_stp[k] = 1; m_prev[k] = d; m_hold[k] = 0;
          if (d == t) m_st[k] = 2;
        end else if (d == m_prev[k]) begin
          m_hold[k]++;
          if (m_hold[k] == 4) begin m_err[k] = 1; m_hold[k] = 0; end
        end else begin
          m_err[k] = 1; m_prev[k] = d; m_hold[k] = 0;
          if (d == t) m_st[k] = 2;
        end
      end else if (d != t) begin
        m_st[k] = 1;
        if (d != 0) m_err[k] = 1;
        if (d >= 0) m_prev[k] = d;
      end
      if (m_err[k] == 1 && m_cnt[k] < 255) m_cnt[k]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 5; k++) upd(k);
    #1;
  endtask

  task automatic drive(int k, logic [3:0] w);
    en_d = '0;
    en_d[k] = 1'b1;
    code_d[k] = w;
    tick();
    en_d = '0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    en_d = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_rst();
    tick();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({o_val[k], o_leg[k], o_stp[k], o_err[k], o_cnt[k], o_done[k], o_st[k], o_prev[k], o_hold[k]} !== 26'd0) begin
        fails++;
        $display("FAIL reset[%0d]: got val=%0d leg=%0d stp=%0d err=%0d cnt=%0d done=%0d st=%0d prev=%0d hold=%0d, expected all 0",
                 k, o_val[k], o_leg[k], o_stp[k], o_err[k], o_cnt[k], o_done[k], o_st[k], o_prev[k], o_hold[k]);
      end
    end
  endtask

  task automatic test_binary_count();
    int steps = 0;
    do_rst();
    for (int v = 0; v < 19; v++) begin
      drive(0, 4'(v > 15 ? 15 : v));
      steps += int'(o_stp[0]);
      if (v == 15) begin
        tests++;
        if (o_done[0] !== 1'b1 || o_st[0] !== 2'd2) begin
          fails++;
          $display("FAIL bin_done_at_15: got done=%0d state=%0d, expected done=1 state=2", o_done[0], o_st[0]);
        end
      end
    end
    tests++;
    if (steps != 15 || o_cnt[0] !== 8'd0 || o_done[0] !== 1'b1 || o_st[0] !== 2'd2) begin
      fails++;
      $display("FAIL bin_count: got steps=%0d cnt=%0d done=%0d state=%0d, expected 15 0 1 2", steps, o_cnt[0], o_done[0], o_st[0]);
    end
  endtask

  task automatic test_aiken();
    int steps = 0;
    do_rst();
    for (int v = 0; v < 10; v++) begin
      drive(3, 4'(enc(3, v)));
      steps += int'(o_stp[3]);
      tests++;
      if (o_val[3] !== 4'(v)) begin
        fails++;
        $display("FAIL aiken_value: got %0d, expected %0d", o_val[3], v);
      end
    end
    tests++;
    if (steps != 9 || o_done[3] !== 1'b1) begin
      fails++;
      $display("FAIL aiken_seq: got steps=%0d done=%0d, expected 9 1", steps, o_done[3]);
    end
    do_rst();
    drive(3, 4'b0000);
    drive(3, 4'b0001);
    drive(3, 4'b0110);
    tests++;
    if (o_leg[3] !== 1'b0 || o_err[3] !== 1'b1 || o_val[3] !== 4'd1 || o_cnt[3] !== 8'd1) begin
      fails++;
      $display("FAIL aiken_illegal: got legal=%0d err=%0d value=%0d cnt=%0d, expected 0 1 1 1", o_leg[3], o_err[3], o_val[3], o_cnt[3]);
    end
  endtask

  task automatic test_stibitz_skip();
    do_rst();
    drive(4, 4'b0011);
    tests++;
    if (o_val[4] !== 4'd0) begin fails++; $display("FAIL stib_v0: got %0d, expected 0", o_val[4]); end
    drive(4, 4'b0100);
    tests++;
    if (o_val[4] !== 4'd1 || o_stp[4] !== 1'b1) begin
      fails++; $display("FAIL stib_v1: got value=%0d step=%0d, expected 1 1", o_val[4], o_stp[4]);
    end
    drive(4, 4'b0110);
    tests++;
    if (o_val[4] !== 4'd3 || o_err[4] !== 1'b1 || o_stp[4] !== 1'b0 || o_prev[4] !== 4'd3) begin
      fails++;
      $display("FAIL stib_skip: got value=%0d err=%0d step=%0d prev=%0d, expected 3 1 0 3", o_val[4], o_err[4], o_stp[4], o_prev[4]);
    end
    drive(4, 4'b0111);
    tests++;
    if (o_stp[4] !== 1'b1 || o_err[4] !== 1'b0) begin
      fails++; $display("FAIL stib_after_skip: got step=%0d err=%0d, expected 1 0", o_stp[4], o_err[4]);
    end
  endtask

  task automatic test_gray_hold();
    int errs = 0;
    do_rst();
    drive(2, 4'b0000);
    drive(2, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      drive(2, 4'b0001);
      tests++;
      if (o_err[2] !== (i == 4) || o_hold[2] !== 4'(i == 4 ? 0 : i)) begin
        fails++;
        $display("FAIL gray_hold_%0d: got err=%0d hold=%0d, expected %0d %0d", i, o_err[2], o_hold[2], i == 4, i == 4 ? 0 : i);
      end
    end
    do_rst();
    drive(2, 4'b0000);
    drive(2, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      drive(2, 4'b0001);
      errs += int'(o_err[2]);
    end
    tests++;
    if (errs != 1 || o_hold[2] !== 4'd2 || o_cnt[2] !== 8'd1) begin
      fails++;
      $display("FAIL gray_six_repeats: got errs=%0d hold=%0d cnt=%0d, expected 1 2 1", errs, o_hold[2], o_cnt[2]);
    end
  endtask

  task automatic test_bcd_restart();
    do_rst();
    for (int v = 0; v < 10; v++) drive(1, 4'(v));
    tests++;
    if (o_st[1] !== 2'd2) begin fails++; $display("FAIL bcd_done: got state=%0d, expected 2", o_st[1]); end
    drive(1, 4'b0000);
    tests++;
    if (o_st[1] !== 2'd1 || o_err[1] !== 1'b0 || o_cnt[1] !== 8'd0 || o_done[1] !== 1'b0) begin
      fails++;
      $display("FAIL bcd_restart: got state=%0d err=%0d cnt=%0d done=%0d, expected 1 0 0 0", o_st[1], o_err[1], o_cnt[1], o_done[1]);
    end
    drive(1, 4'b0001);
    en_d[1] = 1'b1;
    code_d[1] = 4'b0010;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_d = '0;
    tests++;
    if ({o_val[1], o_leg[1], o_stp[1], o_err[1], o_cnt[1], o_done[1], o_st[1], o_prev[1], o_hold[1]} !== 26'd0) begin
      fails++;
      $display("FAIL bcd_rst_priority: got val=%0d leg=%0d stp=%0d err=%0d st=%0d prev=%0d, expected all 0",
               o_val[1], o_leg[1], o_stp[1], o_err[1], o_st[1], o_prev[1]);
    end
  endtask

  task automatic test_saturate();
    do_rst();
    drive(0, 4'd0);
    for (int i = 0; i < 300; i++) drive(0, 4'(i % 2 == 0 ? 5 : 0));
    tests++;
    if (o_cnt[0] !== 8'd255 || o_err[0] !== 1'b1) begin
      fails++; $display("FAIL err_cnt_saturate: got cnt=%0d err=%0d, expected 255 1", o_cnt[0], o_err[0]);
    end
  endtask

  task automatic test_seg();
`ifdef CODE_SEQ_CHK_SEG_EN
    do_rst();
    drive(0, 4'b1000);
    tests++;
    if (o_seg[0] !== 7'b1111111) begin fails++; $display("FAIL seg_8: got %b, expected 1111111", o_seg[0]); end
    drive(1, 4'b1010);
    tests++;
    if (o_seg[1] !== 7'b1000000) begin fails++; $display("FAIL seg_dash: got %b, expected 1000000", o_seg[1]); end
`endif
  endtask

  task automatic test_random();
    int r, t, nv;
    logic [25:0] exp_t, got_t;
    do_rst();
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 199) == 0;
      for (int k = 0; k < 5; k++) begin
        t = term(k);
        r = $urandom_range(0, 99);
        en_d[k] = $urandom_range(0, 9) != 0;
        nv = (m_st[k] == 1 && m_prev[k] < t) ? m_prev[k] + 1 : (r < 25 ? 0 : t);
        code_d[k] = r < 50 ? 4'(enc(k, nv)) : r < 70 ? 4'(enc(k, m_val[k])) :
                    r < 80 ? 4'(enc(k, $urandom_range(0, t))) : 4'($urandom_range(0, 15));
      end
      tick();
      for (int k = 0; k < 5; k++) begin
        exp_t = {4'(m_val[k]), 1'(m_leg[k]), 1'(m_stp[k]), 1'(m_err[k]), 8'(m_cnt[k]), m_st[k] == 2,
                 2'(m_st[k]), 4'(m_prev[k]), 4'(m_hold[k])};
        got_t = {o_val[k], o_leg[k], o_stp[k], o_err[k], o_cnt[k], o_done[k], o_st[k], o_prev[k], o_hold[k]};
        tests++;
        if (got_t !== exp_t) begin
          fails++;
          $display("FAIL random[%0d] cycle %0d: got {val,leg,stp,err,cnt,done,st,prev,hold}=%h, expected %h", k, c, got_t, exp_t);
        end
      end
    end
    rst = 1'b0;
    en_d = '0;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      m_st[k] = 0; m_prev[k] = 0; m_hold[k] = 0; m_val[k] = 0; m_leg[k] = 0; m_cnt[k] = 0; m_stp[k] = 0; m_err[k] = 0;
    end
    test_reset();
    test_binary_count();
    test_aiken();
    test_stibitz_skip();
    test_gray_hold();
    test_bcd_restart();
    test_saturate();
    test_seg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/code_seq_checker.md
# code_seq_checker

Synthesizable receiver for the 4-bit code streams that the simulation generators produce (binary, BCD, Gray, Aiken 2421, Stibitz/excess-3). It samples one code word per strobe and decodes it to a binary digit value. It checks that successive values form the counting sequence the matching generator emits, and reports step, error and completion events. It sits downstream of a code source and upstream of a display or status LEDs.

## Interface
Parameters:
- CODE, default 0, code type: 0 binary, 1 BCD, 2 Gray, 3 Aiken 2421, 4 Stibitz (excess-3); other values are treated as 0.
- HOLD_MAX, default 4, range 1..15; number of consecutive identical samples in TRACK that are accepted before a stuck error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset. Only one clock.
- en  in  1  sample strobe; `code` is evaluated only on edges where en=1.
- code  in  4  input code word, {b3,b2,b1,b0}.
- value  out  4  decoded value of the last legal sample.
- legal  out  1  last sampled code was a legal word of CODE.
- step_ok  out  1  one-cycle pulse: accepted +1 step.
- err  out  1  one-cycle pulse: illegal, skip or stuck error.
- err_cnt  out  8  errors since reset, saturating at 255.
- done  out  1  high while in DONE.
- state  out  2  0 IDLE, 1 TRACK, 2 DONE.

## Operation
- Decode rules:
  - Binary: value=code, all 16 words legal.
  - BCD: legal 0000..1001, value=code.
  - Gray: standard Gray-to-binary conversion, all words legal.
  - Aiken: 0000..0100 decode to 0..4; 1011..1111 decode to 5..9; other words illegal.
  - Stibitz: legal 0011..1100, value=code-3.
- TERM is the last value in the sequence: 15 for binary and Gray, 9 for the others.
- An illegal sample never updates `value` or `prev`.
- Internal registers: prev (4 bits) and hold_cnt (4 bits).
- IDLE: on en with a legal value of 0, go to TRACK with prev=0 and hold_cnt=0. Any other sample is ignored, with no err.
- TRACK, on en. Exactly one of the following applies, in priority order:
  1. Illegal code: err=1; stay in TRACK.
  2. value==prev+1: step_ok=1, prev=value, hold_cnt=0. If value==TERM, go to DONE.
  3. value==prev: hold_cnt+1. When hold_cnt reaches HOLD_MAX, err=1 and hold_cnt=0.
  4. Any other legal value: err=1 (skip), prev=value, hold_cnt=0. If value==TERM, go to DONE.
- DONE: models the generator saturating at its last code.
  - Repeated TERM: no event.
  - Legal 0: go to TRACK with prev=0, no err, counts as a restart.
  - Illegal code or any other value: err=1, go to TRACK. For a legal value, prev=value.
- Each err pulse increments err_cnt unless it is already 255.

## Timing
- All outputs are registered. The response to a sample taken on edge N is visible after edge N, with one-cycle latency.
- step_ok and err are single-cycle pulses and are never both high. With en=0 both are 0 and all state holds.
- Reset values: value=0, legal=0, step_ok=0, err=0, err_cnt=0, done=0, state=IDLE, prev=0, hold_cnt=0.
- rst has priority over en on the same edge.
- A reset asserted mid-sequence returns the block to IDLE. The next sample must be 0 before tracking resumes.
- Back-to-back strobes (en=1 every cycle) are fully supported, with no bubbles.

## Configuration
- Macro: CODE_SEQ_CHK_SEG_EN.
- With the macro defined:
  - An extra output `seg` (7 bits, out) is present, with bit0=a through bit6=g, active-high.
  - It is a registered 7-segment pattern for `value` (hex glyphs 0..F), updated in the same cycle as `value`.
  - An illegal sample shows a dash (only g lit).
  - Reset value is 7'b0000000.
- Without the macro: the `seg` port and its logic are absent. All other behaviour is identical.

## Test plan
- CODE=0, HOLD_MAX=4, en=1, binary count 0..15 then holding 15: 15 step_ok pulses, err_cnt=0, done=1 after the sample of 15, state=2.
- CODE=3, Aiken sequence 0000,0001,0010,0011,0100,1011,…,1111: values 0..9, 9 step_ok pulses, done=1. Injecting 0110 instead gives legal=0, err=1, value unchanged, err_cnt=1.
- CODE=4, stream 0011,0100,0110 (skip 2): value=0, then 1, then 3; err=1 on the third sample; prev=3; the next sample 0111 gives step_ok=1.
- CODE=2, Gray 0000,0001 followed by 0001 held for 4 strobes: err=1 on the 4th repeat and hold_cnt clears. Six identical repeats give only one err.
- CODE=1, count to 9, then code 0000: DONE→TRACK with no err. rst on the same edge as a step: next cycle state=IDLE, outputs at reset values.
- CODE_SEQ_CHK_SEG_EN defined, CODE=0, sample 1000: seg=7'b1111111 one cycle later. Illegal BCD 1010 with CODE=1: seg=7'b1000000.
